// File: rtl/clkmon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
// The period min/max statistics are built only when CLKMON_STATS_EN is defined.
package clkmon_pkg;

  localparam int unsigned FAULT_CNT_W = 8;
  localparam int unsigned MON_STATE_W = 2;

  typedef enum logic [MON_STATE_W-1:0] {
    MON_IDLE    = 2'd0,
    MON_MEASURE = 2'd1,
    MON_LOCKED  = 2'd2,
    MON_FAULT   = 2'd3
  } mon_state_t;

  // Saturating increment for the fault entry counter.
  function automatic logic [FAULT_CNT_W-1:0] fault_cnt_inc(input logic [FAULT_CNT_W-1:0] c);
    if (c == '1) begin
      return c;
    end
    return c + FAULT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/clkmon_edge_sync.sv
// Two-flop synchroniser for the divided clock sampled as data, plus rising-edge detect.
module clkmon_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/clkdiv_ratio_monitor.sv
// Measures fast cycles per divided-clock period and tracks lock/fault status.
// Optional period min/max statistics: define CLKMON_STATS_EN.
module clkdiv_ratio_monitor
  import clkmon_pkg::*;
#(
  parameter int unsigned EXP_RATIO    = 2,
  parameter int unsigned TOL          = 0,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned LOSS_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   div_clk,
  input  logic                   clr_faults,
  output logic                   locked,
  output logic                   fault_pulse,
  output logic [FAULT_CNT_W-1:0] fault_count,
  output logic [CNT_W-1:0]       last_period,
  output logic [MON_STATE_W-1:0] mon_state,
  output logic [CNT_W-1:0]       period_min,
  output logic [CNT_W-1:0]       period_max
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  mon_state_t        state_q;
  mon_state_t        state_d;
  logic [GOOD_W-1:0] good_q;
  logic [GOOD_W-1:0] good_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rise;
  logic              match;
  logic              timeout;
  logic              enter_fault;
  logic [31:0]       cnt_w32;

  clkmon_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (div_clk),
    .rise_c (rise)
  );

  // Period window check done at 32 bits so TOL larger than EXP_RATIO cannot wrap.
  assign cnt_w32 = 32'(cnt_q);
  assign match   = ((cnt_w32 + TOL) >= EXP_RATIO) && (cnt_w32 <= (EXP_RATIO + TOL));
  assign timeout = (cnt_q == CNT_W'(LOSS_TIMEOUT)) && !rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rise) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MON_IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    enter_fault = 1'b0;
    case (state_q)
      MON_IDLE: begin
        // First partial period is never judged; loss of clock is not a fault yet.
        if (rise) begin
          state_d = MON_MEASURE;
          good_d  = '0;
        end
      end
      MON_MEASURE: begin
        if (rise) begin
          if (!match) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            state_d = MON_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else if (timeout) begin
          state_d     = MON_FAULT;
          good_d      = '0;
          enter_fault = 1'b1;
        end
      end
      MON_LOCKED: begin
        if ((rise && !match) || timeout) begin
          state_d     = MON_FAULT;
          good_d      = '0;
          enter_fault = 1'b1;
        end
      end
      MON_FAULT: begin
        // The rise that ends a fault restarts measurement without being judged.
        if (rise) begin
          state_d = MON_MEASURE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = MON_IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked      <= 1'b0;
      fault_pulse <= 1'b0;
      fault_count <= '0;
      last_period <= '0;
    end else begin
      locked      <= (state_d == MON_LOCKED);
      fault_pulse <= enter_fault;
      if (clr_faults) begin
        fault_count <= enter_fault ? FAULT_CNT_W'(1) : '0;
      end else if (enter_fault) begin
        fault_count <= fault_cnt_inc(fault_count);
      end
      if (rise && (state_q != MON_IDLE)) begin
        last_period <= cnt_q;
      end
    end
  end

  assign mon_state = state_q;

`ifdef CLKMON_STATS_EN
  logic             judged;
  logic [CNT_W-1:0] pmin_q;
  logic [CNT_W-1:0] pmax_q;

  assign judged = rise && ((state_q == MON_MEASURE) || (state_q == MON_LOCKED));

  // Clear wins over a judged rise in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pmin_q <= '1;
      pmax_q <= '0;
    end else if (clr_faults) begin
      pmin_q <= '1;
      pmax_q <= '0;
    end else if (judged) begin
      if (cnt_q < pmin_q) begin
        pmin_q <= cnt_q;
      end
      if (cnt_q > pmax_q) begin
        pmax_q <= cnt_q;
      end
    end
  end

  assign period_min = pmin_q;
  assign period_max = pmax_q;
`else
  assign period_min = '0;
  assign period_max = '0;
`endif

endmodule
